stack_unit: RTL

Operand stack for the multicycle stack CPU; sits directly downstream of the controller and executes its push/pop/tos strobes. Push data is selected by MtoS: memory read data or the ALU result. Popped and peeked values land in a registered stack_out, which feeds the A/B operand registers (lda/ldb) and the memory write-data path one cycle later.

---
 rtl/stack_unit.sv | 111 +++++++++++
 1 files changed

// File: rtl/stack_unit.sv
// Operand stack for the multicycle stack CPU: executes push/pop/tos strobes
// from the controller and presents popped/peeked data on a registered stack_out.
module stack_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       tos,
  input  logic                       MtoS,
  input  logic [WIDTH-1:0]           mem_data,
  input  logic [WIDTH-1:0]           alu_res,
  output logic [WIDTH-1:0]           stack_out,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       empty,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       cmd_err
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SPW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("stack_unit: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] stack_out_q, stack_out_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             cmd_err_q, cmd_err_d;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       n_cmd;
  logic             is_full;
  logic             is_empty;

  // Command decode and next-state computation.
  always_comb begin
    sp_d        = sp_q;
    stack_out_d = stack_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    cmd_err_d   = cmd_err_q;
    wr_en       = 1'b0;
    wr_idx      = AW'(sp_q);
    rd_idx      = AW'(sp_q - SPW'(1));
    wr_data     = MtoS ? mem_data : alu_res;
    n_cmd       = 2'(push) + 2'(pop) + 2'(tos);
    is_full     = (sp_q == SPW'(DEPTH));
    is_empty    = (sp_q == '0);

    if (n_cmd > 2'd1) begin
      cmd_err_d = 1'b1;
    end else if (push) begin
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SPW'(1);
      end
    end else if (pop || tos) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        stack_out_d = mem_q[rd_idx];
        if (pop) sp_d = sp_q - SPW'(1);
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_q        <= '0;
      stack_out_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      sp_q        <= sp_d;
      stack_out_q <= stack_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Storage is left uninitialised; entries at or above sp are never read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_data;
  end

  assign stack_out = stack_out_q;
  assign sp        = sp_q;
  assign empty     = (sp_q == '0);
  assign full      = (sp_q == SPW'(DEPTH));
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign cmd_err   = cmd_err_q;

endmodule
